// File: rtl/pzcorebus_response_burst_buffer.sv
// Response-beat circular buffer for pzcorebus, cut-through or store-and-forward.
// Latency: one cycle from push to output. Backpressure: accept drops when full or clearing; no full bypass.
module pzcorebus_response_burst_buffer #(
    parameter int ID_WIDTH          = 8,
    parameter int DATA_WIDTH        = 64,
    parameter int RESPONSE_WIDTH    = 2,
    parameter int DEPTH             = 8,
    parameter int STORE_AND_FORWARD = 0,
    parameter int COUNT_WIDTH       = $clog2(DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clear,
    input  logic                      i_sresp_valid,
    output logic                      o_mresp_accept,
    input  logic [RESPONSE_WIDTH-1:0] i_sresp,
    input  logic [ID_WIDTH-1:0]       i_sid,
    input  logic                      i_serror,
    input  logic [DATA_WIDTH-1:0]     i_sdata,
    input  logic                      i_sresp_last,
    output logic                      o_sresp_valid,
    input  logic                      i_mresp_accept,
    output logic [RESPONSE_WIDTH-1:0] o_sresp,
    output logic [ID_WIDTH-1:0]       o_sid,
    output logic                      o_serror,
    output logic [DATA_WIDTH-1:0]     o_sdata,
    output logic                      o_sresp_last,
    output logic [COUNT_WIDTH-1:0]    o_word_count,
    output logic [COUNT_WIDTH-1:0]    o_burst_count,
    output logic                      o_empty,
    output logic                      o_full,
    output logic                      o_stall_error
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [RESPONSE_WIDTH-1:0] sresp;
        logic [ID_WIDTH-1:0]       sid;
        logic                      serror;
        logic [DATA_WIDTH-1:0]     sdata;
        logic                      last;
    } beat_t;

    beat_t                  mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
    logic [COUNT_WIDTH-1:0] burst_count_q, burst_count_d;
    logic                   stall_error_q, stall_error_d;
    logic                   push, pop, push_last, pop_last;
    logic                   empty, full;
    beat_t                  wr_beat, rd_beat;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty          = (word_count_q == '0);
    assign full           = (word_count_q == COUNT_WIDTH'(DEPTH));
    assign o_mresp_accept = !full && !i_clear;
    assign o_sresp_valid  = !empty && ((STORE_AND_FORWARD == 0) || (burst_count_q != '0));

    assign push      = i_sresp_valid && o_mresp_accept;
    assign pop       = o_sresp_valid && i_mresp_accept;
    assign rd_beat   = mem_q[rd_ptr_q];
    assign push_last = push && i_sresp_last;
    assign pop_last  = pop && rd_beat.last;
    assign wr_beat   = '{sresp: i_sresp, sid: i_sid, serror: i_serror, sdata: i_sdata, last: i_sresp_last};

    assign o_sresp       = rd_beat.sresp;
    assign o_sid         = rd_beat.sid;
    assign o_serror      = rd_beat.serror;
    assign o_sdata       = rd_beat.sdata;
    assign o_sresp_last  = rd_beat.last;
    assign o_word_count  = word_count_q;
    assign o_burst_count = burst_count_q;
    assign o_empty       = empty;
    assign o_full        = full;
    assign o_stall_error = stall_error_q;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        word_count_d  = word_count_q;
        burst_count_d = burst_count_q;
        stall_error_d = stall_error_q;
        if (i_clear) begin
            // A pop handshake seen downstream during the clear is discarded with everything else.
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            word_count_d  = '0;
            burst_count_d = '0;
            stall_error_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            if (push && !pop) word_count_d = word_count_q + 1'b1;
            if (pop && !push) word_count_d = word_count_q - 1'b1;
            if (push_last && !pop_last) burst_count_d = burst_count_q + 1'b1;
            if (pop_last && !push_last) burst_count_d = burst_count_q - 1'b1;
            // Full with no complete burst can never drain in store-and-forward.
            if ((STORE_AND_FORWARD != 0) && full && (burst_count_q == '0)) stall_error_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            word_count_q  <= '0;
            burst_count_q <= '0;
            stall_error_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            word_count_q  <= word_count_d;
            burst_count_q <= burst_count_d;
            stall_error_q <= stall_error_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_beat;
    end

    word_count_no_wrap: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(push && !pop && full) && !(pop && !push && empty));
    burst_count_no_wrap: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(push_last && !pop_last && (burst_count_q == COUNT_WIDTH'(DEPTH))) &&
        !(pop_last && !push_last && (burst_count_q == '0)));

endmodule

// File: tb/tb_pzcorebus_response_burst_buffer.sv
// Bench for pzcorebus_response_burst_buffer: three instances (cut-through d8, store-and-forward d8,
// cut-through d5) checked every cycle against a queue-based model of the buffer contents.
module tb_pzcorebus_response_burst_buffer;

    typedef struct packed {
        logic [1:0]  r;
        logic [7:0]  id;
        logic        err;
        logic [63:0] d;
        logic        last;
    } beat_t;

    localparam int NI = 3;
    localparam int DEP [NI] = '{8, 8, 5};
    localparam int SAF [NI] = '{0, 1, 0};

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  clr     [NI];
    logic  in_vld  [NI];
    beat_t in_b    [NI];
    logic  out_acc [NI];
    logic  out_vld [NI];
    logic  up_acc  [NI];
    beat_t out_b   [NI];
    logic  emp     [NI];
    logic  ful     [NI];
    logic  stl     [NI];
    logic [3:0] wc [NI];
    logic [3:0] bc [NI];

    int n_tests = 0;
    int n_fail  = 0;

    beat_t mq [NI][$];
    bit    mstall [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CW = $clog2(DEP[g] + 1);
        logic          vld_l, acc_l, err_l, last_l, emp_l, ful_l, stl_l;
        logic [1:0]    r_l;
        logic [7:0]    id_l;
        logic [63:0]   d_l;
        logic [CW-1:0] wc_l, bc_l;
        pzcorebus_response_burst_buffer #(
            .DEPTH(DEP[g]), .STORE_AND_FORWARD(SAF[g])
        ) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr[g]),
            .i_sresp_valid(in_vld[g]), .o_mresp_accept(acc_l),
            .i_sresp(in_b[g].r), .i_sid(in_b[g].id), .i_serror(in_b[g].err),
            .i_sdata(in_b[g].d), .i_sresp_last(in_b[g].last),
            .o_sresp_valid(vld_l), .i_mresp_accept(out_acc[g]),
            .o_sresp(r_l), .o_sid(id_l), .o_serror(err_l), .o_sdata(d_l), .o_sresp_last(last_l),
            .o_word_count(wc_l), .o_burst_count(bc_l),
            .o_empty(emp_l), .o_full(ful_l), .o_stall_error(stl_l)
        );
        assign out_vld[g] = vld_l;
        assign up_acc[g]  = acc_l;
        assign out_b[g]   = '{r: r_l, id: id_l, err: err_l, d: d_l, last: last_l};
        assign emp[g]     = emp_l;
        assign ful[g]     = ful_l;
        assign stl[g]     = stl_l;
        assign wc[g]      = 4'(wc_l);
        assign bc[g]      = 4'(bc_l);
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the buffer is a FIFO of beats; valid/accept follow from its size and last count.
    function automatic int m_lasts(int g);
        int n = 0;
        for (int i = 0; i < mq[g].size(); i++) if (mq[g][i].last) n++;
        return n;
    endfunction

    function automatic bit m_vld(int g);
        return (mq[g].size() > 0) && (SAF[g] == 0 || m_lasts(g) > 0);
    endfunction

    function automatic bit m_acc(int g);
        return (mq[g].size() < DEP[g]) && !clr[g];
    endfunction

    task automatic model_step(int g);
        bit do_pop  = m_vld(g) && out_acc[g];
        bit do_push = in_vld[g] && m_acc(g);
        if (clr[g]) begin
            mq[g].delete();
            mstall[g] = 1'b0;
        end else begin
            if (SAF[g] != 0 && mq[g].size() == DEP[g] && m_lasts(g) == 0) mstall[g] = 1'b1;
            if (do_push) mq[g].push_back(in_b[g]);
            if (do_pop) void'(mq[g].pop_front());
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst_n) begin
                mq[g].delete();
                mstall[g] = 1'b0;
            end else begin
                model_step(g);
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            check($sformatf("valid%0d", g), 80'(out_vld[g]), 80'(m_vld(g)));
            check($sformatf("accept%0d", g), 80'(up_acc[g]), 80'(m_acc(g)));
            check($sformatf("empty%0d", g), 80'(emp[g]), 80'(mq[g].size() == 0));
            check($sformatf("full%0d", g), 80'(ful[g]), 80'(mq[g].size() == DEP[g]));
            check($sformatf("words%0d", g), 80'(wc[g]), 80'(mq[g].size()));
            check($sformatf("bursts%0d", g), 80'(bc[g]), 80'(m_lasts(g)));
            check($sformatf("stall%0d", g), 80'(stl[g]), 80'(mstall[g]));
            if (m_vld(g)) check($sformatf("beat%0d", g), 80'(out_b[g]), 80'(mq[g][0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(logic [7:0] id, logic [63:0] d, logic last);
        beat_t b;
        b.r = 2'(d); b.id = id; b.err = d[0]; b.d = d; b.last = last;
        return b;
    endfunction

    task automatic push_beat(int g, beat_t b);
        bit ok = 0;
        in_vld[g] = 1'b1;
        in_b[g]   = b;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = m_acc(g);
            step();
        end
        in_vld[g] = 1'b0;
        if (!ok) check($sformatf("push_timeout%0d", g), 80'(0), 80'(1));
    endtask

    task automatic drain(int g);
        out_acc[g] = 1'b1;
        for (int k = 0; k < 200 && mq[g].size() != 0; k++) step();
        if (mq[g].size() != 0) check($sformatf("drain_timeout%0d", g), 80'(mq[g].size()), 80'(0));
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            clr[g] = 0; in_vld[g] = 0; out_acc[g] = 0; in_b[g] = '0;
        end
        #23 rst_n = 1'b1;
        step();

        // Cut-through: each beat appears one cycle after its push.
        out_acc[0] = 1'b1;
        for (int i = 0; i < 4; i++) push_beat(0, mk(8'd3, 64'hD0 + 64'(i), i == 3));
        drain(0);

        // Store-and-forward: output held until the last beat is stored.
        out_acc[1] = 1'b1;
        for (int i = 0; i < 4; i++) push_beat(1, mk(8'd7, 64'hA0 + 64'(i), i == 3));
        drain(1);

        // Full with downstream stalled, then push and pop together.
        out_acc[1] = 1'b0;
        for (int i = 0; i < 8; i++) push_beat(1, mk(8'(i), 64'hB0 + 64'(i), 1'b1));
        @(negedge clk);
        check("full_flag", 80'(ful[1]), 80'(1));
        check("full_accept", 80'(up_acc[1]), 80'(0));
        step();
        in_vld[1] = 1'b1; in_b[1] = mk(8'hEE, 64'hBAD, 1'b1); out_acc[1] = 1'b1;
        step();
        in_vld[1] = 1'b0; out_acc[1] = 1'b0;
        @(negedge clk);
        check("full_pop_words", 80'(wc[1]), 80'(7));
        step();
        drain(1);

        // Burst longer than the buffer deadlocks store-and-forward.
        for (int i = 0; i < 8; i++) push_beat(1, mk(8'h11, 64'hC0 + 64'(i), 1'b0));
        repeat (3) step();
        check("stall_set", 80'(stl[1]), 80'(1));
        repeat (2) step();
        check("stall_held", 80'(stl[1]), 80'(1));
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        check("clear_words", 80'(wc[1]), 80'(0));
        check("clear_empty", 80'(emp[1]), 80'(1));
        check("clear_stall", 80'(stl[1]), 80'(0));

        // Wrap-around with random backpressure on both sides.
        begin
            int sent = 0;
            in_b[2] = '0;
            for (int k = 0; k < 2000 && sent < 23; k++) begin
                if (!in_vld[2]) begin
                    in_b[2].r = 2'($urandom); in_b[2].id = 8'($urandom); in_b[2].err = 1'($urandom);
                    in_b[2].d = {$urandom, $urandom}; in_b[2].last = ($urandom_range(0, 3) == 0);
                    in_vld[2] = ($urandom_range(0, 2) != 0);
                end
                out_acc[2] = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (in_vld[2] && m_acc(2)) sent++;
                step();
                if (in_vld[2] && mq[2].size() > 0 && mq[2][mq[2].size()-1] == in_b[2]) in_vld[2] = 1'b0;
            end
            in_vld[2] = 1'b0;
            check("wrap_sent", 80'(sent), 80'(23));
            drain(2);
        end

        // Async reset with a partial burst stored.
        out_acc[0] = 1'b0;
        for (int i = 0; i < 3; i++) push_beat(0, mk(8'h42, 64'hE0 + 64'(i), 1'b0));
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 80'(out_vld[0]), 80'(0));
        check("rst_empty", 80'(emp[0]), 80'(1));
        check("rst_words", 80'(wc[0]), 80'(0));
        check("rst_accept", 80'(up_acc[0]), 80'(1));
        check("rst_full", 80'(ful[0]), 80'(0));
        step();
        #2 rst_n = 1'b1;
        step();
        out_acc[0] = 1'b1;
        push_beat(0, mk(8'h99, 64'h1234_5678, 1'b1));
        check("rst_next_beat", 80'(out_b[0]), 80'(mk(8'h99, 64'h1234_5678, 1'b1)));
        check("rst_next_valid", 80'(out_vld[0]), 80'(1));
        drain(0);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
